// File: rtl/frame_play_ctrl_pkg.sv
// Shared types and helpers for the frame playback sequencer.
package frame_play_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_BWD  = 2'd2
  } step_e;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  // One frame forward or backward, wrapping within 0..num_frames-1.
  function automatic logic [7:0] next_idx(input logic [7:0] idx, input logic fwd,
                                          input int num_frames);
    logic [7:0] last;
    last = 8'(num_frames - 1);
    if (fwd) begin
      if (idx >= last) next_idx = 8'd0;
      else             next_idx = idx + 8'd1;
    end else begin
      if (idx == 8'd0) next_idx = last;
      else             next_idx = idx - 8'd1;
    end
  endfunction

endpackage

// File: rtl/frame_play_ctrl_vs_edge_det.sv
// Vertical-sync leading-edge detector; vs is already in the pclk domain.
module frame_play_ctrl_vs_edge_det #(
  parameter bit VS_POL = 1'b0
) (
  input  logic pclk,
  input  logic rstn,
  input  logic vs,
  output logic vs_tick
);

  logic vs_d_r;

  // Previous vs sample, parked at the inactive level during reset
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      vs_d_r <= ~VS_POL;
    end else begin
      vs_d_r <= vs;
    end
  end

  assign vs_tick = (vs == VS_POL) && (vs_d_r != VS_POL);

endmodule

// File: rtl/frame_play_ctrl.sv
// Frame playback sequencer: play/pause, stepping, loop/one-shot on vsync edges.
// Optional ping-pong playback in mode 2'b10 is enabled by defining PINGPONG_EN.
module frame_play_ctrl
  import frame_play_ctrl_pkg::*;
#(
  parameter int NUM_FRAMES = 10,
  parameter int FW         = 4,
  parameter int HW         = 4,
  parameter bit VS_POL     = 1'b0
) (
  input  logic          pclk,
  input  logic          rstn,
  input  logic          vs,
  input  logic          play_pause,
  input  logic          step_fwd,
  input  logic          step_bwd,
  input  logic [1:0]    mode,
  input  logic [HW-1:0] hold,
  output logic [FW-1:0] frame_idx,
  output logic          frame_chg,
  output logic          playing,
  output logic          done,
  output logic [7:0]    led
);

  localparam logic [FW-1:0] LAST_IDX = FW'(NUM_FRAMES - 1);
  localparam logic [FW-1:0] PENULT   = FW'(NUM_FRAMES - 2);

  state_e        state_r, state_s;
  step_e         step_r, step_s;
  logic [HW-1:0] cnt_r, cnt_s;
  logic [FW-1:0] idx_r, idx_s;
  logic          restart_r, restart_s;
  logic          chg_s;
  logic          vs_tick_s;
  logic [HW-1:0] hold_last_s;
`ifdef PINGPONG_EN
  logic          dir_r, dir_s;
  logic          fwd_s;
`endif

  frame_play_ctrl_vs_edge_det #(.VS_POL(VS_POL)) u_vs_edge (
    .pclk    (pclk),
    .rstn    (rstn),
    .vs      (vs),
    .vs_tick (vs_tick_s)
  );

  assign hold_last_s = (hold == '0) ? '0 : (hold - HW'(1));

  // Frame update on vs_tick from the current state, then control pulses on top
  always_comb begin
    state_s   = state_r;
    step_s    = step_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    restart_s = restart_r;
    chg_s     = 1'b0;
`ifdef PINGPONG_EN
    dir_s     = dir_r;
    fwd_s     = 1'b1;
`endif
    if (vs_tick_s) begin
      case (state_r)
        ST_PLAY: begin
          if (restart_r) begin
            idx_s     = '0;
            cnt_s     = '0;
            restart_s = 1'b0;
            chg_s     = 1'b1;
          end else if (cnt_r >= hold_last_s) begin
            cnt_s = '0;
            case (mode)
              MODE_ONESHOT: begin
                if (idx_r == LAST_IDX) begin
                  state_s = ST_DONE;
                end else begin
                  idx_s = idx_r + FW'(1);
                  chg_s = 1'b1;
                  if (idx_r == PENULT) state_s = ST_DONE;
                  else                 state_s = ST_PLAY;
                end
              end
`ifdef PINGPONG_EN
              MODE_PINGPONG: begin
                // Reverse at either end so endpoints are shown only once
                fwd_s = dir_r ? (idx_r == '0) : (idx_r != LAST_IDX);
                idx_s = FW'(next_idx(8'(idx_r), fwd_s, NUM_FRAMES));
                dir_s = ~fwd_s;
                chg_s = 1'b1;
              end
`endif
              default: begin
                idx_s = FW'(next_idx(8'(idx_r), 1'b1, NUM_FRAMES));
                chg_s = 1'b1;
              end
            endcase
          end else begin
            cnt_s = cnt_r + HW'(1);
          end
        end
        ST_PAUSE, ST_DONE: begin
          if (step_r != STEP_NONE) begin
            idx_s  = FW'(next_idx(8'(idx_r), step_r == STEP_FWD, NUM_FRAMES));
            step_s = STEP_NONE;
            chg_s  = 1'b1;
          end else begin
            step_s = STEP_NONE;
          end
        end
        default: begin
          state_s = ST_PAUSE;
        end
      endcase
    end else begin
      cnt_s = cnt_r;
    end

    case (state_s)
      ST_PAUSE: begin
        if (play_pause) begin
          state_s = ST_PLAY;
          cnt_s   = '0;
          step_s  = STEP_NONE;
        end else if (step_bwd) begin
          step_s = STEP_BWD;
        end else if (step_fwd) begin
          step_s = STEP_FWD;
        end else begin
          step_s = step_s;
        end
      end
      ST_PLAY: begin
        if (play_pause) begin
          state_s   = ST_PAUSE;
          restart_s = 1'b0;
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_DONE: begin
        if (play_pause) begin
          state_s   = ST_PLAY;
          restart_s = 1'b1;
          cnt_s     = '0;
        end else if (step_bwd) begin
          state_s = ST_PAUSE;
          step_s  = STEP_BWD;
        end else if (step_fwd) begin
          state_s = ST_PAUSE;
          step_s  = STEP_FWD;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_PAUSE;
      end
    endcase
`ifdef PINGPONG_EN
    dir_s = (mode == MODE_PINGPONG) ? dir_s : 1'b0;
`endif
  end

  // Sequencer state and registered outputs
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_PAUSE;
      step_r    <= STEP_NONE;
      cnt_r     <= '0;
      idx_r     <= '0;
      restart_r <= 1'b0;
      frame_chg <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
      led       <= 8'h00;
    end else begin
      state_r   <= state_s;
      step_r    <= step_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      restart_r <= restart_s;
      frame_chg <= chg_s;
      playing   <= (state_s == ST_PLAY);
      done      <= (state_s == ST_DONE);
      led       <= {(state_s == ST_PLAY), (state_s == ST_DONE), 2'b00, 4'(idx_s)};
    end
  end

`ifdef PINGPONG_EN
  // Ping-pong direction, 1 = backward
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      dir_r <= 1'b0;
    end else begin
      dir_r <= dir_s;
    end
  end
`endif

  assign frame_idx = idx_r;

endmodule

// File: doc/frame_play_ctrl.md
Name: frame_play_ctrl

Overview:
Playback sequencer for the multi-frame VGA video player. It replaces the free-running timer frame counter: it produces the frame index that selects which frame ROM drives the display-data path. Frame changes happen only on the display's vertical-sync edge, so frames never tear, and the playback rate is expressed as a number of display frames per video frame. Supports play/pause, single-step forward/backward while paused, and loop and one-shot playback modes.

Parameters:
NUM_FRAMES, 10, number of stored video frames (2..16)
FW, 4, frame index width; must satisfy 2^FW >= NUM_FRAMES
HW, 4, width of hold (display frames per video frame) input
VS_POL, 0, active level of vs input (0 = active-low)

Ports:
pclk  in  1  pixel clock, 50 MHz; all logic on rising edge
rstn  in  1  asynchronous active-low reset
vs  in  1  vertical sync from the display scan timing block, pclk domain
play_pause  in  1  one-cycle pulse, already debounced; toggles play/pause
step_fwd  in  1  one-cycle pulse; advance one frame (paused only)
step_bwd  in  1  one-cycle pulse; go back one frame (paused only)
mode  in  2  00 loop, 01 one-shot, 10 ping-pong (macro-gated), 11 = loop
hold  in  HW  display frames per video frame; 0 treated as 1
frame_idx  out  FW  current frame index to the ROM data select
frame_chg  out  1  one-cycle pulse, coincident with the frame_idx update
playing  out  1  1 in PLAY state
done  out  1  1 in DONE state (one-shot finished)
led  out  8  {playing, done, 2'b0, frame_idx zero-extended to 4 bits}

Behaviour:
- Reset values: frame_idx=0, frame_chg=0, playing=0, done=0, state=PAUSE, hold counter=0, step pending=none, vs_d = inactive level. Reset is asynchronous and can occur at any point; all state returns to reset values immediately.
- vs_tick: asserted in a cycle when vs is sampled active and vs_d (registered vs) is inactive. vs is synchronous to pclk, so no synchronizer is needed.
- Frame updates take effect only on a vs_tick cycle. frame_idx is registered at the end of that cycle, and frame_chg is high for the following cycle only. Latency from vs edge to frame_idx change is 1 cycle.
- States: PAUSE, PLAY, DONE.
- PAUSE:
  - play_pause → PLAY, and the hold counter clears.
  - step_fwd or step_bwd latches a pending direction. If several arrive before a vs_tick, the last one wins (steps are coalesced, one frame moved).
  - At vs_tick with a step pending: frame_idx moves ±1 with wrap (NUM_FRAMES-1 ↔ 0) in every mode, and the pending step clears.
- PLAY:
  - Each vs_tick increments the hold counter.
  - When the counter reaches max(hold,1)-1, the counter clears and the frame advances. hold is sampled at each comparison, so a change takes effect mid-period; if the counter already exceeds the new value, the advance happens on the next tick.
  - Advance in loop mode: idx+1, wrapping to 0 after NUM_FRAMES-1.
  - Advance in one-shot mode: idx+1; on reaching NUM_FRAMES-1 → DONE with idx held at NUM_FRAMES-1.
  - play_pause → PAUSE; the hold counter is kept, frame_idx is unchanged.
  - Step pulses are ignored.
- DONE:
  - play_pause → PLAY with frame_idx=0, applied at the next vs_tick with frame_chg.
  - Step pulses behave as in PAUSE and move to PAUSE.
- Simultaneous events:
  - play_pause together with a step in the same cycle: play_pause wins, the step is dropped.
  - A control pulse in a vs_tick cycle: the frame update uses the pre-pulse state; the state change applies after.
- A mode change is applied at the next advance. Switching to one-shot while idx=NUM_FRAMES-1 → DONE at the next advance.

Optional Feature:
PINGPONG_EN:
- Defined: mode 10 is ping-pong. A direction register (reset = forward) controls advancing. The direction reverses at NUM_FRAMES-1 and at 0, so the sequence is 0..N-1, N-2..0, 1... with endpoints not repeated. The direction register clears on leaving ping-pong mode.
- Undefined: mode 10 behaves as loop and no direction register exists.

Decomposition:
- Shared package holds:
  - state encoding (ST_PAUSE, ST_PLAY, ST_DONE)
  - mode constants (MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG)
  - a next-index helper function (wrap ±1 modulo NUM_FRAMES)
- One sub-module: vs_edge_det (register plus edge compare, VS_POL parameter, outputs vs_tick).

Test Plan:
- Reset, then hold=3, mode=00, play_pause: frame_idx steps 0→1→...→9→0, changing every 3rd vs_tick; frame_chg is exactly one cycle per change.
- mode=01, hold=1, play: idx reaches 9, then done=1 and playing=0, and idx stays 9 for 5 further vs_ticks. A play_pause then gives idx=0 at the next tick, with playing=1.
- Paused at idx=0: step_bwd gives idx=9 at the next vs_tick. step_fwd, step_fwd, step_bwd within one frame gives a single move back (9→8).
- play_pause and step_fwd in the same cycle while paused: state becomes PLAY and no step occurs. While playing, step pulses have no effect.
- hold=0 treated as 1 (advance every vs_tick). Asserting rstn low mid-play at idx=5 gives idx=0, PAUSE and led=0 immediately, with no clock needed.
- PINGPONG_EN defined, mode=10, hold=1: sequence 0..9, 8..0, 1. Undefined: mode=10 matches the loop sequence.
